data_memory_ctrl: RTL and testbench

Multi-cycle data-memory responder for the MEM stage of the 5-stage pipeline. It accepts load/store requests from the EX/MEM pipeline register and holds the whole pipeline with a stall while an access of configurable latency completes. It returns load data on the port that feeds the MEM/WB register's memory-data input. It owns the data-memory word array.

---
 rtl/data_memory_ctrl.sv | 85 ++++++++
 tb/tb_data_memory_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory: fixed-latency load/store responder that stalls the
// whole pipeline until the access completes, and owns the word array.
module data_memory_ctrl #(
    parameter int LATENCY     = 4,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        memRead_i,
    input  logic        memWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] writeData_i,
    output logic [31:0] memData_o,
    output logic        stall_o
);
    // state | meaning
    // IDLE  | waiting; a request here raises stall and starts the access
    // BUSY  | counting down LATENCY cycles; access commits when cnt hits 0
    // DONE  | single cycle, stall low, memData_o valid; pipeline advances

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, stateNext;
    logic [3:0]       cnt, cntNext;
    logic             request;
    logic             access;
    logic [IDX_W-1:0] index;
    logic [31:0]      mem [DEPTH_WORDS];
    logic             unusedAddr;

    assign request    = memRead_i | memWrite_i;
    assign index      = addr_i[IDX_W+1:2];
    assign unusedAddr = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        stall_o   = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                stall_o = request;
                if (request) begin
                    stateNext = BUSY;
                    cntNext   = 4'(LATENCY - 1);
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (cnt != 4'd0) begin
                    cntNext = cnt - 4'd1;
                end else begin
                    access    = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            memData_o <= 32'h0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (access && memRead_i) begin
                memData_o <= mem[index];
            end
        end
    end

    // Array is never cleared; NBA ordering gives read-before-write on read+write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && access && memWrite_i) begin
            mem[index] <= writeData_i;
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: one LATENCY=4 instance and one
// LATENCY=1 instance, each test task checking its own expected values.
module tb_data_memory_ctrl;
    logic        clk = 1'b0;
    logic        rst4, rd4, wr4, stall4;
    logic [31:0] addr4, wdata4, data4;
    logic        rst1, rd1, wr1, stall1;
    logic [31:0] addr1, wdata1, data1;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.LATENCY(4), .DEPTH_WORDS(1024)) dut4 (
        .clk_i(clk), .rst_i(rst4), .memRead_i(rd4), .memWrite_i(wr4),
        .addr_i(addr4), .writeData_i(wdata4), .memData_o(data4), .stall_o(stall4)
    );

    data_memory_ctrl #(.LATENCY(1), .DEPTH_WORDS(1024)) dut1 (
        .clk_i(clk), .rst_i(rst1), .memRead_i(rd1), .memWrite_i(wr1),
        .addr_i(addr1), .writeData_i(wdata1), .memData_o(data1), .stall_o(stall1)
    );

    // Presents one request to dut4, counts stall cycles, returns DONE-cycle data.
    task automatic run4(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output int stallCycles,
                        output logic [31:0] doneData);
        int guard;
        @(posedge clk); #1;
        rd4 = rd; wr4 = wr; addr4 = addr; wdata4 = wdata;
        #1;
        stallCycles = 0;
        guard = 0;
        while (stall4 === 1'b1 && guard < 40) begin
            stallCycles++;
            guard++;
            @(posedge clk); #2;
        end
        if (guard >= 40) begin
            checks++;
            failures++;
            $display("FAIL run4_timeout stall still high after %0d cycles, required low", guard);
        end
        doneData = data4;
        rd4 = 1'b0; wr4 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic store1(input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk); #1;
        wr1 = 1'b1; addr1 = addr; wdata1 = wdata;
        repeat (2) @(posedge clk);
        #1;
        wr1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst4 = 1'b1; rst1 = 1'b1;
        rd4 = 0; wr4 = 0; addr4 = 0; wdata4 = 0;
        rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if (data4 !== 32'h0 || stall4 !== 1'b0) begin
                failures++;
                $display("FAIL reset4 cycle %0d data=%h stall=%b, required data=0 stall=0", c, data4, stall4);
            end
            checks++;
            if (data1 !== 32'h0 || stall1 !== 1'b0) begin
                failures++;
                $display("FAIL reset1 cycle %0d data=%h stall=%b, required data=0 stall=0", c, data1, stall1);
            end
        end
        rst4 = 1'b0; rst1 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (stall4 !== 1'b0 || data4 !== 32'h0) begin
                failures++;
                $display("FAIL idle4 cycle %0d stall=%b data=%h, required stall=0 data=0", c, stall4, data4);
            end
        end
    endtask

    task automatic test_store_load;
        int          sc;
        logic [31:0] d;
        run4(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, sc, d);
        checks++;
        if (sc !== 5) begin
            failures++;
            $display("FAIL store_stall cycles=%0d, required 5", sc);
        end
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL store_data memData=%h, required 00000000", d);
        end
        run4(1'b1, 1'b0, 32'h10, 32'h0, sc, d);
        checks++;
        if (sc !== 5) begin
            failures++;
            $display("FAIL load_stall cycles=%0d, required 5", sc);
        end
        checks++;
        if (d !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL load_data memData=%h, required deadbeef", d);
        end
        checks++;
        if (data4 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL load_hold memData=%h, required deadbeef", data4);
        end
    endtask

    task automatic test_aliasing;
        int          sc;
        logic [31:0] d;
        run4(1'b0, 1'b1, 32'h13, 32'h12345678, sc, d);
        run4(1'b1, 1'b0, 32'h10 + 32'd4096, 32'h0, sc, d);
        checks++;
        if (d !== 32'h12345678) begin
            failures++;
            $display("FAIL alias_data memData=%h, required 12345678", d);
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0]  pat;
        logic [31:0] d0, d1;
        store1(32'h0, 32'hA0A0A0A0);
        store1(32'h4, 32'hB4B4B4B4);
        @(posedge clk); #1;
        rd1 = 1'b1; addr1 = 32'h0;
        d0 = 32'h0; d1 = 32'h0;
        for (int c = 0; c < 6; c++) begin
            #1;
            pat[c] = stall1;
            if (c == 2) begin
                d0 = data1;
                addr1 = 32'h4;
            end
            if (c == 5) begin
                d1 = data1;
                rd1 = 1'b0;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (pat !== 6'b011011) begin
            failures++;
            $display("FAIL b2b_stall pattern(c5..c0)=%b, required 011011", pat);
        end
        checks++;
        if (d0 !== 32'hA0A0A0A0) begin
            failures++;
            $display("FAIL b2b_data0 memData=%h, required a0a0a0a0", d0);
        end
        checks++;
        if (d1 !== 32'hB4B4B4B4) begin
            failures++;
            $display("FAIL b2b_data1 memData=%h, required b4b4b4b4", d1);
        end
    endtask

    task automatic test_reset_mid_store;
        int          sc;
        logic [31:0] d;
        run4(1'b0, 1'b1, 32'h20, 32'h11111111, sc, d);
        @(posedge clk); #1;
        wr4 = 1'b1; addr4 = 32'h20; wdata4 = 32'hAAAA5555;
        repeat (2) @(posedge clk);
        #1;
        rst4 = 1'b1; wr4 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if (stall4 !== 1'b0 || data4 !== 32'h0) begin
                failures++;
                $display("FAIL midrst cycle %0d stall=%b data=%h, required stall=0 data=0", c, stall4, data4);
            end
        end
        rst4 = 1'b0;
        run4(1'b1, 1'b0, 32'h20, 32'h0, sc, d);
        checks++;
        if (d !== 32'h11111111) begin
            failures++;
            $display("FAIL midrst_load memData=%h, required 11111111", d);
        end
    endtask

    task automatic test_read_write;
        int          sc;
        logic [31:0] d;
        run4(1'b0, 1'b1, 32'h30, 32'h1, sc, d);
        run4(1'b1, 1'b1, 32'h30, 32'h2, sc, d);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL rw_old memData=%h, required 00000001", d);
        end
        run4(1'b1, 1'b0, 32'h30, 32'h0, sc, d);
        checks++;
        if (d !== 32'h2) begin
            failures++;
            $display("FAIL rw_new memData=%h, required 00000002", d);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_aliasing();
        test_back_to_back();
        test_reset_mid_store();
        test_read_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
